// File: rtl/rice_pkg.sv
// rice_pkg: shared state type, widths and symbol packing for the Rice decode sequencer
package rice_pkg;
    localparam int         WORD_W = 16;
    localparam int         SYM_W  = 16;
    localparam logic [4:0] QMAX   = 5'd31;

    typedef enum logic [2:0] {IDLE, UNARY, REM, EMIT, ERR} state_t;

    // Returns {overflow, q*2^k + r}; r only ever occupies the low k bits.
    function automatic logic [SYM_W:0] rice_pack(input logic [4:0] q, input logic [SYM_W-1:0] r,
                                                 input logic [3:0] k);
        logic [SYM_W+4:0] qs;
        qs = {{SYM_W{1'b0}}, q} << k;
        return {|qs[SYM_W+4:SYM_W], qs[SYM_W-1:0] | r};
    endfunction
endpackage

// File: rtl/rice_lzc.sv
// rice_lzc: combinational 16-bit leading-zero count
// Ports: d = word to scan, lz = number of leading zeros, zero = d has no set bit
module rice_lzc (
    input  logic [15:0] d,
    output logic [4:0]  lz,
    output logic        zero
);
    always_comb begin
        lz   = 5'd0;
        zero = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (zero && d[i]) zero = 1'b0;
            else if (zero) lz = lz + 5'd1;
        end
    end
endmodule

// File: rtl/rice_decode_seq.sv
// rice_decode_seq: self-timed Rice (Golomb power-of-two) bitstream decode sequencer
// Ports: start/k/nsym begin a block; in_valid/in_ready/in_data carry 16-bit words,
//        MSB first; sym_valid/sym_ready/sym_data carry q*2^k + r; busy, done
//        (one-cycle pulse) and err (sticky until next start) report block status.
// Build option: define RICE_FAST_UNARY_EN to consume a whole zero run plus its
//        terminating '1' in one cycle using rice_lzc.
module rice_decode_seq
    import rice_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        k,
    input  logic [15:0]       nsym,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic [SYM_W-1:0]  sym_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state;
    logic [WORD_W-1:0] sbuf;
    logic [4:0]        fill, q, u_n;
    logic [3:0]        kr, rcnt;
    logic [15:0]       nr, cnt;
    logic [SYM_W-1:0]  r, rr;
    logic [5:0]        u_q;
    logic              u_hit, u_err;
    logic [SYM_W:0]    pk;

    assign in_ready = (state == UNARY || state == REM) && fill == 5'd0;

    // Unary step: u_n bits consumed, u_q is the quotient afterwards, u_hit when the '1' was seen.
`ifdef RICE_FAST_UNARY_EN
    logic [4:0] lz;
    logic       zero;
    rice_lzc u_lzc (.d(sbuf), .lz(lz), .zero(zero));
    // Bits shifted in behind the valid ones are zero, so any set bit found is a real one.
    assign u_hit = !zero;
    assign u_n   = zero ? fill : lz + 5'd1;
    assign u_q   = {1'b0, q} + {1'b0, zero ? fill : lz};
`else
    assign u_hit = sbuf[WORD_W-1];
    assign u_n   = 5'd1;
    assign u_q   = {1'b0, q} + {5'd0, !u_hit};
`endif
    assign u_err = u_q > {1'b0, QMAX};
    assign rr    = state == REM ? {r[SYM_W-2:0], sbuf[WORD_W-1]} : '0;
    // Symbol (and its overflow) for whichever state is about to enter EMIT.
    assign pk    = rice_pack(state == REM ? q : u_q[4:0], rr, kr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sbuf      <= '0;
            fill      <= '0;
            q         <= '0;
            r         <= '0;
            kr        <= '0;
            rcnt      <= '0;
            nr        <= '0;
            cnt       <= '0;
            sym_valid <= 1'b0;
            sym_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_valid && in_ready) begin
                sbuf <= in_data;
                fill <= 5'(WORD_W);
            end
            case (state)
                IDLE: if (start) begin
                    kr    <= k[3:0];
                    nr    <= nsym;
                    cnt   <= '0;
                    err   <= 1'b0;
                    fill  <= '0;
                    q     <= '0;
                    r     <= '0;
                    state <= k > 5'd15 ? ERR : nsym == 16'd0 ? IDLE : UNARY;
                    busy  <= k < 5'd16 && nsym != 16'd0;
                    done  <= k < 5'd16 && nsym == 16'd0;
                end
                UNARY: if (fill != 5'd0) begin
                    if (u_err) state <= ERR;
                    else begin
                        sbuf <= sbuf << u_n;
                        fill <= fill - u_n;
                        q    <= u_q[4:0];
                        if (u_hit && kr != 4'd0) begin
                            state <= REM;
                            r     <= '0;
                            rcnt  <= kr;
                        end else if (u_hit) begin
                            state     <= pk[SYM_W] ? ERR : EMIT;
                            sym_valid <= !pk[SYM_W];
                            sym_data  <= pk[SYM_W-1:0];
                        end
                    end
                end
                REM: if (fill != 5'd0) begin
                    sbuf <= sbuf << 1;
                    fill <= fill - 5'd1;
                    r    <= rr;
                    rcnt <= rcnt - 4'd1;
                    if (rcnt == 4'd1) begin
                        state     <= pk[SYM_W] ? ERR : EMIT;
                        sym_valid <= !pk[SYM_W];
                        sym_data  <= pk[SYM_W-1:0];
                    end
                end
                EMIT: if (sym_ready) begin
                    sym_valid <= 1'b0;
                    q         <= '0;
                    cnt       <= cnt + 16'd1;
                    if (cnt + 16'd1 == nr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fill  <= '0;
                    end else state <= UNARY;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    fill  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rice_decode_seq.sv
// tb_rice_decode_seq: randomized scoreboard bench for the Rice decode sequencer
module tb_rice_decode_seq;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [4:0]  k = '0;
    logic [15:0] nsym = '0, in_data, sym_data;
    logic        in_valid, in_ready, sym_valid, sym_ready, busy, done, err;

    int          total = 0, bad = 0;
    logic [15:0] wq[$];
    int          sb[$];
    int          m_syms[$];
    bit          m_err, m_ok;
    int          m_bits;
    int          taken = 0, base = 0, done_cnt = 0, vmode = 1, rmode = 1;
    bit          in_hs = 1'b0;

`ifdef RICE_FAST_UNARY_EN
    localparam int EXP_LAT = 6;
`else
    localparam int EXP_LAT = 9;
`endif

    rice_decode_seq dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .nsym(nsym),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int getbit(input int i);
        logic [15:0] w;
        w = wq[i / 16];
        return int'(w[15 - i % 16]);
    endfunction

    // Reference decoder over the word list: bit i of the stream is bit 15-(i%16) of word i/16.
    function automatic void model(input int kk, input int ns);
        int p, q, r;
        p = 0;
        m_syms.delete();
        m_err  = 1'b0;
        m_ok   = 1'b1;
        m_bits = 0;
        if (kk > 15) begin
            m_err = 1'b1;
            return;
        end
        for (int s = 0; s < ns; s++) begin
            q = 0;
            while (1) begin
                if (p >= 16 * wq.size()) begin m_ok = 1'b0; return; end
                p++;
                if (getbit(p - 1) == 1) break;
                q++;
                if (q > 31) begin m_err = 1'b1; m_bits = p; return; end
            end
            r = 0;
            for (int j = 0; j < kk; j++) begin
                if (p >= 16 * wq.size()) begin m_ok = 1'b0; return; end
                r = r * 2 + getbit(p);
                p++;
            end
            if (q * (1 << kk) > 65535) begin m_err = 1'b1; m_bits = p; return; end
            m_syms.push_back(q * (1 << kk) + r);
        end
        m_bits = p;
    endfunction

    // Upstream word source and downstream ready generator.
    initial begin
        int idx;
        in_valid  = 1'b0;
        in_data   = '0;
        sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            if (in_hs) taken++;
            #1;
            idx       = taken - base;
            in_valid  = idx < wq.size() && (vmode == 1 || $urandom_range(3) != 0);
            in_data   = idx < wq.size() ? wq[idx] : 16'h0;
            sym_ready = rmode == 1 ? 1'b1 : rmode == 2 ? 1'b0 : $urandom_range(2) != 0;
        end
    end

    // Monitor: pops the scoreboard on every symbol handshake.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            in_hs = in_valid && in_ready;
            if (done) done_cnt++;
            if (sym_valid && sym_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sym_unexpected: got %0d expected none", sym_data);
                end else begin
                    e = sb.pop_front();
                    check("sym_data", sym_data, e);
                end
            end
        end
    end

    task automatic run_block(input int kk, input int ns, input bit bp, input bit chk_lat);
        int  cyc, lat, d0;
        bit  prev_err, fin;
        logic [15:0] held;
        model(kk, ns);
        foreach (m_syms[i]) sb.push_back(m_syms[i]);
        base     = taken;
        d0       = done_cnt;
        prev_err = err;
        k        = kk[4:0];
        nsym     = ns[15:0];
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        lat = -1;
        fin = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            if (cyc == 1 && prev_err) check("err_clear", err, 0);
            if (sym_valid && lat < 0) begin
                lat = cyc;
                if (bp) begin
                    held = sym_data;
                    repeat (5) begin
                        @(posedge clk);
                        @(negedge clk);
                        check("bp_valid", sym_valid, 1);
                        check("bp_data", sym_data, held);
                        check("bp_in_ready", in_ready, 0);
                    end
                    rmode = 1;
                end
            end
            if (done || err) begin fin = 1'b1; break; end
            @(posedge clk);
            cyc++;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL timeout: k=%0d nsym=%0d got no done/err expected one", kk, ns);
        end
        repeat (2) @(negedge clk);
        if (chk_lat) check("latency", lat, EXP_LAT);
        check("err", err, m_err);
        check("done_pulses", done_cnt - d0, m_err ? 0 : 1);
        check("words", taken - base, (m_bits + 15) / 16);
        check("sb_left", sb.size(), 0);
        check("busy_end", busy, 0);
        sb.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit bq[$];
        int kk, ns, qm, qv, rv, mode;
        logic [15:0] w;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sym_data", sym_data, 0);
        @(posedge clk); #2 reset = 1'b0;

        wq.delete(); wq.push_back(16'h1680);
        run_block(3, 2, 0, 1);
        wq.delete(); wq.push_back(16'h0000); wq.push_back(16'hC000);
        run_block(2, 1, 0, 0);
        wq.delete(); wq.push_back(16'h8000);
        run_block(0, 1, 0, 0);
        wq.delete();
        run_block(5, 0, 0, 0);
        wq.delete(); wq.push_back(16'h1680);
        rmode = 2;
        run_block(3, 2, 1, 0);
        wq.delete(); wq.push_back(16'h0000); wq.push_back(16'h0000);
        run_block(2, 1, 0, 0);
        wq.delete(); wq.push_back(16'h2000); wq.push_back(16'hA5A5); wq.push_back(16'h5A5A);
        run_block(15, 1, 0, 0);
        wq.delete();
        run_block(16, 1, 0, 0);
        wq.delete(); wq.push_back(16'h1680);
        run_block(3, 2, 0, 0);

        wq.delete(); wq.push_back(16'h8000); wq.push_back(16'h1234); wq.push_back(16'h5678);
        base = taken; k = 5'd15; nsym = 16'd1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("busy_mid", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 0);
        check("arst_sym_valid", sym_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err, 0);
        check("arst_sym_data", sym_data, 0);
        sb.delete();
        @(posedge clk); #2 reset = 1'b0;
        wq.delete(); wq.push_back(16'h1680);
        run_block(3, 2, 0, 0);

        vmode = 0;
        rmode = 0;
        for (int b = 0; b < 60; b++) begin
            mode = $urandom_range(9);
            wq.delete();
            if (mode == 0) begin
                run_block($urandom_range(15), 0, 0, 0);
            end else if (mode <= 3) begin
                kk = $urandom_range(16);
                ns = $urandom_range(3, 1);
                for (int t = 0; t < 20; t++) begin
                    wq.delete();
                    repeat (16) wq.push_back($urandom_range(3) == 0 ? 16'h0 : 16'($urandom_range(65535)));
                    model(kk, ns);
                    if (m_ok) break;
                end
                if (m_ok) run_block(kk, ns, 0, 0);
            end else begin
                kk = $urandom_range(15);
                ns = $urandom_range(6, 1);
                qm = (1 << (16 - kk)) - 1;
                if (qm > 31) qm = 31;
                bq.delete();
                for (int s = 0; s < ns; s++) begin
                    qv = $urandom_range(qm);
                    rv = kk == 0 ? 0 : $urandom_range((1 << kk) - 1);
                    repeat (qv) bq.push_back(1'b0);
                    bq.push_back(1'b1);
                    for (int j = kk - 1; j >= 0; j--) bq.push_back(rv[j]);
                end
                while (bq.size() % 16 != 0) bq.push_back(1'($urandom_range(1)));
                for (int i = 0; i < bq.size(); i += 16) begin
                    for (int j = 0; j < 16; j++) w[15 - j] = bq[i + j];
                    wq.push_back(w);
                end
                wq.push_back(16'($urandom_range(65535)));
                wq.push_back(16'($urandom_range(65535)));
                run_block(kk, ns, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
